// File: rtl/iommu_reg_if_adapter.sv
// iommu_reg_if_adapter
//   Register-bus slave adapter in front of the IOMMU register fields.
//   Accepts one single-beat read/write request at a time, decodes the byte
//   address to a register index, issues a one-cycle write-enable (with
//   byte-merged data) or read pulse, then returns a response.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   req_*                        request channel (valid/ready, write, addr, wdata, wstrb)
//   rsp_*                        response channel (valid/ready, rdata, error)
//   reg_we_o / reg_re_o          one-hot write / read pulses, one bit per register
//   reg_wd_o                     merged write data, shared by all registers
//   reg_qs_i                     current register values, register i at [i*DW +: DW]
module iommu_reg_if_adapter #(
  parameter int              NREGS = 16,
  parameter int              DW    = 32,
  parameter int              AW    = 12,
  parameter logic [AW-1:0]   BASE  = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_write_i,
  input  logic [AW-1:0]       req_addr_i,
  input  logic [DW-1:0]       req_wdata_i,
  input  logic [DW/8-1:0]     req_wstrb_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DW-1:0]       rsp_rdata_o,
  output logic                rsp_error_o,
  output logic [NREGS-1:0]    reg_we_o,
  output logic [NREGS-1:0]    reg_re_o,
  output logic [DW-1:0]       reg_wd_o,
  input  logic [NREGS*DW-1:0] reg_qs_i
);
  localparam int BW  = DW / 8;
  localparam int LSB = $clog2(BW);
  localparam int IW  = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [AW:0]       NREGS_A = NREGS[AW:0];
  localparam logic [NREGS-1:0]  ONE     = {{(NREGS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, RESP} state_t;
  state_t state;

  logic          wr_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [BW-1:0] wstrb_q;
  logic [IW-1:0] idx_q;
  logic          err_q;

  // Offset is formed in AW+1 bits: a borrow out of the subtraction lands in
  // the top bit, which flags addr < BASE without wrapping into a valid index.
  logic [AW:0]   off;
  logic          dec_err;
  logic [IW-1:0] dec_idx;
  always_comb begin
    off     = {1'b0, addr_q} - {1'b0, BASE};
    dec_err = off[AW] || (off[LSB-1:0] != '0) || ((off >> LSB) >= NREGS_A);
    dec_idx = off[LSB +: IW];
  end

  // Merge uses the register value as seen in the EXEC cycle itself.
  logic [DW-1:0] qs, mask;
  always_comb begin
    qs   = reg_qs_i[idx_q*DW +: DW];
    mask = '0;
    for (int b = 0; b < BW; b++) mask[b*8 +: 8] = {8{wstrb_q[b]}};
  end

  assign reg_wd_o = (state == EXEC && wr_q && !err_q) ? ((qs & ~mask) | (wdata_q & mask)) : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_error_o <= 1'b0;
      reg_we_o    <= '0;
      reg_re_o    <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      idx_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid_i) begin
          wr_q        <= req_write_i;
          addr_q      <= req_addr_i;
          wdata_q     <= req_wdata_i;
          wstrb_q     <= req_wstrb_i;
          req_ready_o <= 1'b0;
          state       <= DECODE;
        end
        DECODE: begin
          idx_q <= dec_idx;
          err_q <= dec_err;
          // Pulses are registered here so they are high exactly in EXEC.
          if (!dec_err) begin
            if (wr_q) reg_we_o <= ONE << dec_idx;
            else      reg_re_o <= ONE << dec_idx;
          end
          state <= EXEC;
        end
        EXEC: begin
          reg_we_o    <= '0;
          reg_re_o    <= '0;
          rsp_rdata_o <= (!err_q && !wr_q) ? qs : '0;
          rsp_error_o <= err_q;
          rsp_valid_o <= 1'b1;
          state       <= RESP;
        end
        RESP: if (rsp_ready_i) begin
          rsp_valid_o <= 1'b0;
          rsp_rdata_o <= '0;
          rsp_error_o <= 1'b0;
          req_ready_o <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iommu_reg_if_adapter.sv
// Self-checking bench for iommu_reg_if_adapter (NREGS=16, DW=32, BASE=0).
// The bench also plays the role of the register fields: it stores reg_wd_o
// into its register array on every reg_we_o pulse and drives reg_qs_i from it.
module tb_iommu_reg_if_adapter;
  localparam int NREGS = 16;
  localparam int DW    = 32;
  localparam int AW    = 12;
  localparam int BASE_I = 0;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [AW-1:0]     req_addr = '0;
  logic [DW-1:0]     req_wdata = '0;
  logic [DW/8-1:0]   req_wstrb = '0;
  logic              rsp_valid, rsp_ready = 1'b0, rsp_error;
  logic [DW-1:0]     rsp_rdata;
  logic [NREGS-1:0]  reg_we, reg_re;
  logic [DW-1:0]     reg_wd;
  logic [NREGS*DW-1:0] reg_qs;

  iommu_reg_if_adapter #(.NREGS(NREGS), .DW(DW), .AW(AW), .BASE(12'h000)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_error_o(rsp_error), .reg_we_o(reg_we), .reg_re_o(reg_re),
    .reg_wd_o(reg_wd), .reg_qs_i(reg_qs));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register fields driven by the adapter's write port.
  logic [DW-1:0] regs [NREGS] = '{default: '0};
  always @(posedge clk)
    for (int i = 0; i < NREGS; i++) if (reg_we[i]) regs[i] <= reg_wd;
  always_comb begin
    reg_qs = '0;
    for (int i = 0; i < NREGS; i++) reg_qs[i*DW +: DW] = regs[i];
  end

  // Reference model state: what software should see in each register.
  logic [DW-1:0] model [NREGS];

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Expected result of one access, from the address-map rules.
  task automatic ref_model(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                           input logic [3:0] ws, output bit e, output logic [NREGS-1:0] we,
                           output logic [NREGS-1:0] re, output logic [DW-1:0] wdo,
                           output logic [DW-1:0] rd);
    int off, idx;
    off = int'(a) - BASE_I;
    e = (off < 0) || (off % 4 != 0) || (off / 4 >= NREGS);
    we = '0; re = '0; wdo = '0; rd = '0;
    if (!e) begin
      idx = off / 4;
      if (wr) begin
        we[idx] = 1'b1;
        for (int b = 0; b < 4; b++)
          wdo[b*8 +: 8] = ws[b] ? wd[b*8 +: 8] : model[idx][b*8 +: 8];
      end else begin
        re[idx] = 1'b1;
        rd = model[idx];
      end
    end
  endtask

  // Run one access with 'hold' cycles of response back-pressure and compare
  // everything observed against the expectations given.
  task automatic do_check(input string nm, input bit wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [3:0] ws, input int hold,
                          input bit e_err, input logic [NREGS-1:0] e_we,
                          input logic [NREGS-1:0] e_re, input logic [DW-1:0] e_wd,
                          input logic [DW-1:0] e_rd);
    int w, k, npulse, pofs, rsp_k;
    logic [NREGS-1:0] we_s, re_s;
    logic [DW-1:0] wd_s, rd0;
    bit err0, stable, leak;
    req_write = wr; req_addr = a; req_wdata = wd; req_wstrb = ws; req_valid = 1'b1;
    for (w = 0; w < 20 && !req_ready; w++) begin @(posedge clk); #1; end
    if (!req_ready) begin
      chk({nm, ".accept_timeout"}, 0, 1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    npulse = 0; pofs = -1; we_s = '0; re_s = '0; wd_s = '0; leak = 0; rsp_k = -1;
    for (k = 1; k <= 10; k++) begin
      if (reg_we != '0 || reg_re != '0) begin
        npulse++; pofs = k; we_s |= reg_we; re_s |= reg_re; wd_s = reg_wd;
      end else if (reg_wd != '0) leak = 1;
      if (rsp_valid) begin rsp_k = k; break; end
      @(posedge clk); #1;
    end
    chk({nm, ".rsp_latency"}, rsp_k, 3);
    if (rsp_k < 0) return;
    chk({nm, ".npulse"}, npulse, e_err ? 0 : 1);
    if (!e_err) chk({nm, ".pulse_ofs"}, pofs, 2);
    chk({nm, ".we"}, we_s, e_we);
    chk({nm, ".re"}, re_s, e_re);
    if (wr && !e_err) chk({nm, ".wd"}, wd_s, e_wd);
    chk({nm, ".wd_idle"}, leak, 0);
    chk({nm, ".error"}, rsp_error, e_err);
    chk({nm, ".rdata"}, rsp_rdata, e_rd);
    rd0 = rsp_rdata; err0 = rsp_error; stable = 1;
    repeat (hold) begin
      @(posedge clk); #1;
      if (!rsp_valid || rsp_rdata !== rd0 || rsp_error !== err0 || req_ready ||
          reg_we != '0 || reg_re != '0) stable = 0;
    end
    if (hold > 0) chk({nm, ".stable"}, stable, 1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({nm, ".ready_after"}, {rsp_valid, req_ready}, 2'b01);
    for (int i = 0; i < NREGS; i++) if (e_we[i]) model[i] = e_wd;
  endtask

  typedef struct {
    bit wr; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [3:0] wstrb; int hold;
    bit err; logic [NREGS-1:0] we; logic [NREGS-1:0] re; logic [DW-1:0] wd; logic [DW-1:0] rd;
  } vec_t;

  initial begin
    vec_t vt [9];
    int acc [3];
    int accepts, pulses;
    bit hs, e, rbad;
    logic [NREGS-1:0] xwe, xre;
    logic [DW-1:0] xwd, xrd, xdat;
    logic [AW-1:0] ra;
    int sel;

    //          wr addr    wdata         strb    hold err we       re       wd            rd
    vt[0] = '{1, 12'h008, 32'hDEADBEEF, 4'hF,   0, 0, 16'h0004, 16'h0000, 32'hDEADBEEF, 32'h0};
    vt[1] = '{1, 12'h00C, 32'h11223344, 4'hF,   0, 0, 16'h0008, 16'h0000, 32'h11223344, 32'h0};
    vt[2] = '{1, 12'h00C, 32'hAABBCCDD, 4'b0101,0, 0, 16'h0008, 16'h0000, 32'h11BB33DD, 32'h0};
    vt[3] = '{1, 12'h03C, 32'h0000CAFE, 4'hF,   0, 0, 16'h8000, 16'h0000, 32'h0000CAFE, 32'h0};
    vt[4] = '{0, 12'h03C, 32'h0,        4'h0,   5, 0, 16'h0000, 16'h8000, 32'h0,        32'h0000CAFE};
    vt[5] = '{0, 12'h040, 32'h0,        4'h0,   0, 1, 16'h0000, 16'h0000, 32'h0,        32'h0};
    vt[6] = '{1, 12'h006, 32'h12345678, 4'hF,   0, 1, 16'h0000, 16'h0000, 32'h0,        32'h0};
    vt[7] = '{1, 12'h008, 32'h55555555, 4'h0,   1, 0, 16'h0004, 16'h0000, 32'hDEADBEEF, 32'h0};
    vt[8] = '{0, 12'h00C, 32'h0,        4'h0,   2, 0, 16'h0000, 16'h0008, 32'h0,        32'h11BB33DD};

    for (int i = 0; i < NREGS; i++) model[i] = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset.ready", req_ready, 1);
    chk("reset.rsp", {rsp_valid, rsp_error, rsp_rdata}, '0);
    chk("reset.pulses", {reg_we, reg_re, reg_wd}, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++)
      do_check($sformatf("vec%0d", i), vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].wstrb,
               vt[i].hold, vt[i].err, vt[i].we, vt[i].re, vt[i].wd, vt[i].rd);

    // Back-to-back writes with the response side always ready.
    rsp_ready = 1'b1; req_write = 1'b1; req_wstrb = 4'hF;
    req_addr = 12'h010; req_wdata = 32'hB0B0_0000; req_valid = 1'b1;
    accepts = 0; pulses = 0;
    for (int c = 0; c < 40 && accepts < 3; c++) begin
      if (reg_we != '0) pulses++;
      hs = req_valid && req_ready;
      if (hs) begin acc[accepts] = cyc; accepts++; end
      @(posedge clk); #1;
      if (hs) begin
        if (accepts == 3) req_valid = 1'b0;
        else begin
          req_addr  = 12'h010 + 12'(4 * accepts);
          req_wdata = 32'hB0B0_0000 + 32'(accepts);
        end
      end
    end
    repeat (6) begin
      if (reg_we != '0) pulses++;
      @(posedge clk); #1;
    end
    rsp_ready = 1'b0;
    chk("b2b.accepts", accepts, 3);
    if (accepts == 3) begin
      chk("b2b.gap1", acc[1] - acc[0], 4);
      chk("b2b.gap2", acc[2] - acc[0], 8);
    end
    chk("b2b.pulses", pulses, 3);
    for (int i = 0; i < 3; i++) model[4 + i] = 32'hB0B0_0000 + 32'(i);

    // Reset asserted in the EXEC cycle of a write.
    req_write = 1'b1; req_addr = 12'h014; req_wdata = 32'h5555AAAA; req_wstrb = 4'hF;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_exec.pulse", reg_we, 16'h0020);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_exec.ready", req_ready, 1);
    chk("rst_exec.outputs", {rsp_valid, rsp_error, rsp_rdata, reg_we, reg_re, reg_wd}, '0);
    rbad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (rsp_valid || reg_we != '0 || reg_re != '0) rbad = 1;
    end
    chk("rst_exec.quiet", rbad, 0);
    // Resynchronise register 5 and show the next request is handled normally.
    ref_model(1, 12'h014, 32'h0BADF00D, 4'hF, e, xwe, xre, xwd, xrd);
    do_check("rst_exec.next", 1, 12'h014, 32'h0BADF00D, 4'hF, 0, e, xwe, xre, xwd, xrd);

    // Randomized accesses against the reference model.
    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)       ra = 12'($urandom_range(0, NREGS - 1) * 4);
      else if (sel == 7) ra = 12'($urandom_range(0, NREGS - 1) * 4 + $urandom_range(1, 3));
      else               ra = 12'($urandom_range(NREGS, 1023) * 4);
      hs   = 1'($urandom_range(0, 1));
      xdat = $urandom;
      ref_model(hs, ra, xdat, 4'($urandom_range(0, 15)), e, xwe, xre, xwd, xrd);
      // ref_model consumed a fresh strobe; recompute with a fixed one for the DUT call.
      sel = $urandom_range(0, 15);
      ref_model(hs, ra, xdat, 4'(sel), e, xwe, xre, xwd, xrd);
      do_check($sformatf("rnd%0d", t), hs, ra, xdat, 4'(sel), $urandom_range(0, 2),
               e, xwe, xre, xwd, xrd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
